// File: rtl/nono_pkg.sv
// Shared token encoding, FSM states and error causes for the nonogram clue stream parser.
package nono_pkg;

  typedef enum logic [2:0] {
    OP_STOP       = 3'b000,
    OP_LINE_END   = 3'b001,
    OP_OPT_END    = 3'b010,
    OP_SET        = 3'b101,
    OP_LINE_START = 3'b110,
    OP_DIM        = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_M,
    S_LINES,
    S_IN_LINE,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_OPCODE = 3'd1,
    ERR_SEQ    = 3'd2,
    ERR_RANGE  = 3'd3,
    ERR_OVF    = 3'd4,
    ERR_COUNT  = 3'd5
  } err_code_e;

  localparam int TOK_OPC_MSB = 15;
  localparam int TOK_OPC_LSB = 13;
  localparam int TOK_DIM_SEL = 12;
  localparam int TOK_VAL_MSB = 7;
  localparam int TOK_VAL_LSB = 0;

  // Opcodes 011 and 100 are unassigned.
  function automatic logic opc_legal(input logic [2:0] opc);
    return !(opc == 3'b011 || opc == 3'b100);
  endfunction

endpackage

// File: rtl/nono_opt_fifo.sv
// Small synchronous FIFO with registered storage output and a port that flags the tail entry as last.
module nono_opt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         mark_last_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         can_push_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, tail;
  logic [AW:0]   cnt_q;
  logic          pop, full, do_push, mark_ok;

  assign valid_o    = (cnt_q != '0);
  assign data_o     = mem_q[rd_q];
  assign pop        = valid_o && ready_i;
  assign full       = (cnt_q == DEPTH_C);
  assign can_push_o = !full || pop;
  assign do_push    = push_i && can_push_o;
  assign tail       = wr_q - 1'b1;
  // A tail entry leaving this very cycle can no longer be re-marked.
  assign mark_ok    = mark_last_i && valid_o && !(pop && cnt_q == ONE_C);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (mark_ok) mem_q[tail][W-1] <= 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/nono_stream_parser.sv
// Byte-serial nonogram clue parser: assembles 16-bit tokens, sequences rows then columns,
// and streams per-line option bitmaps through a backpressured FIFO with sticky error reporting.
module nono_stream_parser
  import nono_pkg::*;
#(
  parameter int MAX_DIM    = 11,
  parameter int MAX_OPTS   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     byte_in,
  input  logic                           valid_in,
  output logic [MAX_DIM-1:0]             opt_data,
  output logic [$clog2(2*MAX_DIM)-1:0]   opt_line,
  output logic                           opt_is_col,
  output logic                           opt_last,
  output logic                           opt_valid,
  input  logic                           opt_ready,
  output logic [$clog2(MAX_DIM+1)-1:0]   m,
  output logic [$clog2(MAX_DIM+1)-1:0]   n,
  output logic                           line_done,
  output logic [$clog2(MAX_OPTS+1)-1:0]  line_opt_count,
  output logic                           board_done,
  output logic                           err,
  output logic [2:0]                     err_code
);

  localparam int LINE_W = $clog2(2*MAX_DIM);
  localparam int DIM_W  = $clog2(MAX_DIM+1);
  localparam int CNT_W  = $clog2(MAX_OPTS+1);
  localparam int ENT_W  = 2 + LINE_W + MAX_DIM;
  localparam logic [7:0]       MAX_DIM_B  = 8'(MAX_DIM);
  localparam logic [CNT_W-1:0] MAX_OPTS_C = CNT_W'(MAX_OPTS);

  logic             armed_q, phase_q, tok_vld_q;
  logic [7:0]       hi_q;
  logic [15:0]      tok_q;
  state_e           state_q, state_d;
  err_code_e        err_code_q, err_code_d, fault;
  logic [DIM_W-1:0] m_q, m_d, n_q, n_d, line_len;
  logic [LINE_W:0]  line_q, line_d, total;
  logic [MAX_DIM-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, loc_q, loc_d;
  logic             line_done_q, line_done_d;
  logic             push, mark, can_push, is_col, enter_halt;
  logic [ENT_W-1:0] fifo_in, fifo_out;
  opcode_e          opc;
  logic [7:0]       tok_val;
  logic             dim_sel, dim_bad, set_bad;
  logic             unused_tok;

  assign opc        = opcode_e'(tok_q[TOK_OPC_MSB:TOK_OPC_LSB]);
  assign tok_val    = tok_q[TOK_VAL_MSB:TOK_VAL_LSB];
  assign dim_sel    = tok_q[TOK_DIM_SEL];
  assign unused_tok = ^tok_q[11:8];
  assign dim_bad    = (tok_val == 8'd0) || (tok_val > MAX_DIM_B);
  assign total      = (LINE_W+1)'(m_q) + (LINE_W+1)'(n_q);
  assign is_col     = (line_q >= (LINE_W+1)'(m_q));
  assign line_len   = is_col ? m_q : n_q;
  assign set_bad    = (tok_val >= 8'(line_len));
  assign enter_halt = (state_d == S_DONE || state_d == S_ERROR) && (state_d != state_q);

  // Byte assembly: the first edge after reset release is deliberately blind to valid_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q   <= 1'b0;
      phase_q   <= 1'b1;
      hi_q      <= '0;
      tok_q     <= '0;
      tok_vld_q <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      tok_vld_q <= 1'b0;
      if (enter_halt) begin
        phase_q <= 1'b1;
      end else if (valid_in && armed_q) begin
        if (phase_q) begin
          hi_q    <= byte_in;
          phase_q <= 1'b0;
        end else begin
          tok_q     <= {hi_q, byte_in};
          tok_vld_q <= 1'b1;
          phase_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    line_d      = line_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    loc_d       = loc_q;
    line_done_d = 1'b0;
    err_code_d  = err_code_q;
    push        = 1'b0;
    mark        = 1'b0;
    fault       = ERR_NONE;
    if (tok_vld_q && state_q != S_DONE && state_q != S_ERROR) begin
      if (!opc_legal(tok_q[TOK_OPC_MSB:TOK_OPC_LSB])) begin
        fault = ERR_OPCODE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (opc == OP_DIM && !dim_sel) begin
              if (dim_bad) fault = ERR_RANGE;
              else begin
                m_d     = tok_val[DIM_W-1:0];
                state_d = S_GOT_M;
              end
            end else fault = ERR_SEQ;
          end
          S_GOT_M: begin
            if (opc == OP_DIM && dim_sel) begin
              if (dim_bad) fault = ERR_RANGE;
              else begin
                n_d     = tok_val[DIM_W-1:0];
                state_d = S_LINES;
              end
            end else fault = ERR_SEQ;
          end
          S_LINES: begin
            if (opc == OP_LINE_START && line_q < total) begin
              work_d  = '0;
              cnt_d   = '0;
              state_d = S_IN_LINE;
            end else if (opc == OP_STOP) begin
              if (line_q == total) state_d = S_DONE;
              else fault = ERR_COUNT;
            end else fault = ERR_SEQ;
          end
          S_IN_LINE: begin
            case (opc)
              OP_SET: begin
                if (set_bad) fault = ERR_RANGE;
                else work_d = work_q | (MAX_DIM'(1) << tok_val);
              end
              OP_OPT_END: begin
                if (!can_push) fault = ERR_OVF;
                else if (cnt_q == MAX_OPTS_C) fault = ERR_COUNT;
                else begin
                  push   = 1'b1;
                  work_d = '0;
                  cnt_d  = cnt_q + 1'b1;
                end
              end
              OP_LINE_END: begin
                if (cnt_q == '0) fault = ERR_COUNT;
                else begin
                  mark        = 1'b1;
                  line_done_d = 1'b1;
                  loc_d       = cnt_q;
                  line_d      = line_q + 1'b1;
                  state_d     = S_LINES;
                end
              end
              default: fault = ERR_SEQ;
            endcase
          end
          default: ;
        endcase
      end
      if (fault != ERR_NONE) begin
        err_code_d = fault;
        state_d    = S_ERROR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      line_q      <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      loc_q       <= '0;
      line_done_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      line_q      <= line_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      loc_q       <= loc_d;
      line_done_q <= line_done_d;
      err_code_q  <= err_code_d;
    end
  end

  // Entry layout, MSB first: last, is_col, line, bitmap.
  assign fifo_in = {1'b0, is_col, line_q[LINE_W-1:0], work_q};

  nono_opt_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .data_i      (fifo_in),
    .mark_last_i (mark),
    .ready_i     (opt_ready),
    .data_o      (fifo_out),
    .valid_o     (opt_valid),
    .can_push_o  (can_push)
  );

  assign opt_last       = fifo_out[ENT_W-1];
  assign opt_is_col     = fifo_out[ENT_W-2];
  assign opt_line       = fifo_out[ENT_W-3 -: LINE_W];
  assign opt_data       = fifo_out[MAX_DIM-1:0];
  assign m              = m_q;
  assign n              = n_q;
  assign line_done      = line_done_q;
  assign line_opt_count = loc_q;
  assign board_done     = (state_q == S_DONE);
  assign err            = (state_q == S_ERROR);
  assign err_code       = err_code_q;

endmodule
